// File: rtl/async_fifo_wptr_ctrl.sv
// Write-side pointer controller for the dual-clock FIFO: binary/Gray write pointers,
// read-pointer synchroniser, and registered full / almost-full / level flags.

module async_fifo_wptr_gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    // Each binary bit is the XOR of all Gray bits at or above it; no ripple chain.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign bin[gi] = ^gray[WIDTH-1:gi];
    end
endmodule

module async_fifo_wptr_ctrl #(
    parameter int DEPTH_LOG2         = 4,
    parameter int SYNC_STAGES        = 2,
    parameter int ALMOST_FULL_THRESH = 14
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  wr_en,
    output logic [DEPTH_LOG2-1:0] wr_addr,
    output logic [DEPTH_LOG2:0]   wptr_gray,
    input  logic [DEPTH_LOG2:0]   rptr_gray_async,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  almost_full
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] AF_THRESH = PW'(ALMOST_FULL_THRESH);
    // Inverting the top two Gray bits gives the pointer exactly one depth ahead.
    localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW-2){1'b0}}};

    logic [PW-1:0] wbin_reg;
    logic [PW-1:0] wgray_reg;
    logic [PW-1:0] level_reg;
    logic          full_reg;
    logic          almost_full_reg;
    logic [PW-1:0] sync_reg [SYNC_STAGES];

    logic [PW-1:0] rsync;
    logic [PW-1:0] rbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] level_next;

    assign rsync = sync_reg[SYNC_STAGES-1];

    async_fifo_wptr_gray2bin #(
        .WIDTH (PW)
    ) u_rptr_g2b (
        .gray (rsync),
        .bin  (rbin)
    );

    // A write in the reset cycle is suppressed so the RAM never sees a stray strobe.
    assign wr_ready = ~full_reg;
    assign wr_en    = wr_valid & ~full_reg & ~srst;

    assign wbin_next  = wbin_reg + {{(PW-1){1'b0}}, wr_en};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;
    assign level_next = wbin_next - rbin;

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg[0] <= rptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wbin_reg        <= '0;
            wgray_reg       <= '0;
            level_reg       <= '0;
            full_reg        <= 1'b0;
            almost_full_reg <= 1'b0;
        end else begin
            wbin_reg        <= wbin_next;
            wgray_reg       <= wgray_next;
            level_reg       <= level_next;
            full_reg        <= (wgray_next == (rsync ^ FULL_MASK));
            almost_full_reg <= (level_next >= AF_THRESH);
        end
    end

    assign wr_addr     = wbin_reg[DEPTH_LOG2-1:0];
    assign wptr_gray   = wgray_reg;
    assign level       = level_reg;
    assign full        = full_reg;
    assign almost_full = almost_full_reg;

endmodule

// File: doc/async_fifo_wptr_ctrl.md
Name: async_fifo_wptr_ctrl

Overview:
Write-side pointer controller for the dual-clock FIFO used between router ports. It keeps the binary and Gray write pointers and synchronises the read-domain Gray pointer into this clock domain. It converts that pointer to binary with the existing gray-to-binary converter block (WIDTH = DEPTH_LOG2+1), then produces full, almost-full, fill level and the RAM write strobe and address. Its Gray pointer output feeds the read-side synchroniser and gray-to-binary stage.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth; pointer width PW = DEPTH_LOG2+1.
SYNC_STAGES, 2, number of flops in the read-pointer synchroniser (minimum 2).
ALMOST_FULL_THRESH, 14, level at or above which almost_full asserts (must be at most 2**DEPTH_LOG2).

Ports:
clk  input  1  write-domain clock; all logic is on its rising edge.
srst  input  1  synchronous reset, active-high.
wr_valid  input  1  write request from the producer.
wr_ready  output  1  FIFO can accept a word (= ~full).
wr_en  output  1  RAM write strobe (= wr_valid & wr_ready).
wr_addr  output  DEPTH_LOG2  RAM write address (= wbin[DEPTH_LOG2-1:0]).
wptr_gray  output  PW  registered Gray write pointer, sent to the read domain.
rptr_gray_async  input  PW  Gray read pointer from the read domain, asynchronous to clk.
level  output  PW  words stored, as seen through the synchronised read pointer.
full  output  1  registered full flag.
almost_full  output  1  registered, level_next >= ALMOST_FULL_THRESH.

Behaviour:
- Reset (srst=1 at an edge) clears the following, taking effect on the next cycle:
  - wbin=0, wptr_gray=0, all synchroniser flops=0, full=0, almost_full=0, level=0.
  - As a result wr_ready=1 and wr_addr=0.
  - srst overrides any concurrent write.
- Synchroniser:
  - rptr_gray_async passes through a SYNC_STAGES flop chain; rsync is the last stage.
  - No logic sits before the first flop.
  - rbin = gray-to-binary conversion of rsync (combinational).
- Next-state logic:
  - wbin_next = wbin + wr_en (mod 2**PW).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Registered updates each cycle:
  - wbin <= wbin_next and wptr_gray <= wgray_next.
  - full <= (wgray_next == {~rsync[PW-1:PW-2], rsync[PW-3:0]}).
  - level <= (wbin_next - rbin) mod 2**PW.
  - almost_full <= (wbin_next - rbin) >= ALMOST_FULL_THRESH.
- wr_en and wr_ready are combinational from the registered full flag and wr_valid. A write presented while full=1 is dropped (wr_en=0) and the pointer is held.
- Latency:
  - Write at edge N: wptr_gray/level/full reflect it after edge N.
  - Read-pointer advance: visible in full/level after SYNC_STAGES+1 edges, so full is pessimistic and never optimistic.
- Boundaries:
  - Full: level = 2**DEPTH_LOG2 exactly when full=1; level never exceeds 2**DEPTH_LOG2.
  - Empty: level=0 when rsync equals wptr_gray.
  - Wrap-around: the pointer wraps from 2**PW-1 to 0. wptr_gray changes by exactly one bit on every increment, including at the wrap. This is mandatory because the output crosses clock domains.
  - Simultaneous write and read-pointer advance in the same cycle: both are applied in one update, and level is net of both.
- wptr_gray must come straight from a flop, with no combinational path to the port.

Test Plan:
- Reset: assert srst 2 cycles during random traffic -> next cycle wptr_gray=00000, level=0, full=0, almost_full=0, wr_ready=1, wr_addr=0.
- Fill: rptr_gray_async=00000, wr_valid=1 for 20 cycles -> exactly 16 wr_en pulses with wr_addr 0..15. full=1 the cycle after the 16th write, with level=16, wptr_gray=11000; almost_full=1 from level 14.
- Drain visibility: from full, set rptr_gray_async=00110 (bin 4) -> full and level unchanged for 2 cycles; after the 3rd edge full=0, level=12, wr_ready=1.
- Wrap: reader tracks writer with a 3-cycle lag across 40 writes -> wptr_gray steps 10000 to 00000 at the bin 31 to 0 wrap; Hamming distance 1 on every change; no spurious full.
- Blocked write: full=1 with wr_valid=1 for 5 cycles -> wr_en=0 and wptr_gray stable throughout.
- Mid-operation reset: after 7 writes (level=7), pulse srst with wr_valid=1 -> next cycle all outputs at reset values; no write issued in the srst cycle.
